// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: WIDTH-bit operands fed LSB-first through one full_add2 cell.
// Optional subtract mode is enabled with the SERIAL_ADD_SUB_EN macro.

module full_add2 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_sum, fa_cout;
  logic             sub_c;
  logic             accept_c;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_c = sub;
`else
  assign sub_c = 1'b0;
`endif

  assign accept_c = (state_q == S_IDLE) && in_valid;

  full_add2 u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; unused encodings fall back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_RUN;
      S_RUN:  if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand shifters, carry, bit counter and result accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept_c) begin
      a_q     <= op_a;
      b_q     <= op_b ^ {WIDTH{sub_c}};
      carry_q <= sub_c;
      cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      res_q   <= {fa_sum, res_q[WIDTH-1:1]};
      a_q     <= {1'b0, a_q[WIDTH-1:1]};
      b_q     <= {1'b0, b_q[WIDTH-1:1]};
      carry_q <= fa_cout;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  // Handshake/status flags decode straight from the state register
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign carry_out = (state_q == S_DONE) && carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): transaction-level model plus directed vectors.

module tb_serial_add_ctrl;
  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         busy;

  int n_cmp = 0;
  int n_fail = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0=waiting for operands, 1=computing, 2=holding result
  int           m_phase = 0;
  int           m_left = 0;
  logic [W-1:0] m_res = '0;
  logic         m_cy = 1'b0;
  int           acc_cnt = 0;
  int           hs_cnt = 0;
  int           cyc = 0;
  int           last_acc = -1;
  bit           stream = 1'b0;

  function automatic logic m_sub_now();
`ifdef SERIAL_ADD_SUB_EN
    return sub;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
    end else begin
      logic [W:0] full;
      cyc++;
      case (m_phase)
        0: if (in_valid) begin
          if (m_sub_now())
            full = {1'b0, op_a} + {1'b0, ~op_b} + (W+1)'(1);
          else
            full = {1'b0, op_a} + {1'b0, op_b};
          m_res   = full[W-1:0];
          m_cy    = full[W];
          m_phase = 1;
          m_left  = W;
          acc_cnt++;
          if (stream && last_acc >= 0) chk("accept_spacing", cyc - last_acc, W + 2);
          last_acc = cyc;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_ready) begin
          m_phase = 0;
          hs_cnt++;
        end
      endcase
    end
  end

  // Every out-of-reset cycle: status flags and, when valid, the result
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", int'(in_ready), int'(m_phase == 0));
      chk("busy", int'(busy), int'(m_phase == 1));
      chk("out_valid", int'(out_valid), int'(m_phase == 2));
      if (m_phase == 2) begin
        chk("model_result", int'(result), int'(m_res));
        chk("model_carry", int'(carry_out), int'(m_cy));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    n = acc_cnt;
    op_a = a;
    op_b = b;
`ifdef SERIAL_ADD_SUB_EN
    sub = s;
`else
    if (s) $display("note: subtract requested without subtract support");
`endif
    in_valid = 1'b1;
    for (int k = 0; k < 40 && acc_cnt == n; k++) tick();
    in_valid = 1'b0;
    if (acc_cnt == n) chk("accept_timeout", 0, 1);
  endtask

  // Called right after the accept edge; returns edges until out_valid and busy-high samples
  task automatic wait_done(output int lat, output int nbusy);
    lat = 0;
    nbusy = int'(busy);
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
      if (busy) nbusy++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] er, input logic ec);
    int lat, nb;
    send(a, b, s);
    wait_done(lat, nb);
    chk({name, "_latency"}, lat, W);
    chk({name, "_busy_cycles"}, nb, W);
    chk({name, "_result"}, int'(result), int'(er));
    chk({name, "_carry"}, int'(carry_out), int'(ec));
    tick();
  endtask

  initial begin
    int lat, nb, n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = '0;
    op_b = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    #3;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_carry", int'(carry_out), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    out_ready = 1'b1;
    run_op("ff_plus_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("5a_plus_25", 8'h5A, 8'h25, 1'b0, 8'h7F, 1'b0);

    // Consumer stalls: result held, no new accept even with in_valid/out_ready interplay
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0);
    wait_done(lat, nb);
    chk("stall_latency", lat, W);
    n = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      op_a = op_a + 8'h37;
      tick();
      chk("stall_result", int'(result), 8'h33);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("stall_no_accept", acc_cnt, n);
    chk("release_idle", int'(in_ready), 1);
    chk("release_out_valid", int'(out_valid), 0);

    // Async reset partway through an operation
    send(8'h0A, 8'h0B, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_carry", int'(carry_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("midrst_no_output", hs_cnt, acc_cnt - 1);
    hs_cnt = acc_cnt;
    run_op("03_plus_04", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op("10_minus_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    run_op("01_minus_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
    sub = 1'b0;
`endif

    // Back-to-back stream with random operands
    stream = 1'b1;
    last_acc = -1;
    n = acc_cnt;
    in_valid = 1'b1;
    for (int k = 0; k < 50 * (W + 2) + 50 && acc_cnt < n + 50; k++) begin
      op_a = W'($urandom);
      op_b = W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("stream_accepts", acc_cnt - n, 50);
    stream = 1'b0;
    repeat (W + 4) tick();
    chk("handshakes", hs_cnt, acc_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
